// File: rtl/mem_stage_pipe.sv
`default_nettype none
// ============================================================================
// mem_stage_pipe : handshaked Y86 memory stage with wait states and sticky halt
// Revision 1.0
// ============================================================================
module mem_stage_pipe #(
   parameter int DATA_WID    = 32,
   parameter int ADDR_WID    = 32,
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          icode,
   input  logic [DATA_WID-1:0] valA,
   input  logic [DATA_WID-1:0] valE,
   input  logic [DATA_WID-1:0] valP,
   input  logic                instr_valid,
   input  logic                imem_error,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_icode,
   output logic [DATA_WID-1:0] out_valE,
   output logic [DATA_WID-1:0] valM,
   output logic [2:0]          stat,
   output logic                dmem_error
);

   localparam int OFF_W = $clog2(DATA_WID / 8);
   localparam int IDX_W = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;
   localparam logic [1:0] S_HALT   = 2'd3;

   localparam logic [2:0] C_AOK = 3'd1;
   localparam logic [2:0] C_HLT = 3'd2;
   localparam logic [2:0] C_ADR = 3'd3;
   localparam logic [2:0] C_INS = 3'd4;

   logic [1:0]          r_state;
   logic [3:0]          r_cnt;
   logic [3:0]          r_icode;
   logic [DATA_WID-1:0] r_valE;
   logic [DATA_WID-1:0] r_valM;
   logic [DATA_WID-1:0] r_wdata;
   logic [IDX_W-1:0]    r_idx;
   logic [2:0]          r_stat;
   logic                r_derr;
   logic                r_rd;
   logic                r_wr;
   logic [DATA_WID-1:0] r_mem [DEPTH];

   logic                w_is_rd;
   logic                w_is_wr;
   logic                w_mem;
   logic [DATA_WID-1:0] w_sel;
   logic [DATA_WID-1:0] w_wdata;
   logic [ADDR_WID-1:0] w_addr;
   logic [ADDR_WID-1:0] w_word;
   logic                w_misal;
   logic                w_oor;
   logic                w_derr;
   logic                w_fault;
   logic [2:0]          w_stat;
   logic                w_commit_wr;

   always_comb begin
      w_is_rd = 1'b0;
      w_is_wr = 1'b0;
      w_sel   = valE;
      w_wdata = valA;
      case (icode)
         4'h4:    w_is_wr = 1'b1;
         4'h5:    w_is_rd = 1'b1;
         4'h8:    begin w_is_wr = 1'b1; w_wdata = valP; end
         4'hA:    w_is_wr = 1'b1;
         4'h9:    begin w_is_rd = 1'b1; w_sel = valA; end
         4'hB:    begin w_is_rd = 1'b1; w_sel = valA; end
         default: ;
      endcase
   end

   // Word index beyond the array shows up as nonzero bits above IDX_W.
   assign w_mem   = w_is_rd | w_is_wr;
   assign w_addr  = ADDR_WID'(w_sel);
   assign w_word  = w_addr >> OFF_W;
   assign w_misal = (w_addr & ADDR_WID'((1 << OFF_W) - 1)) != '0;
   assign w_oor   = (w_word >> IDX_W) != '0;
   assign w_derr  = w_mem & (w_misal | w_oor);
   assign w_fault = imem_error | ~instr_valid | w_derr;

   always_comb begin
      if (imem_error || w_derr)  w_stat = C_ADR;
      else if (!instr_valid)     w_stat = C_INS;
      else if (icode == 4'h0)    w_stat = C_HLT;
      else                       w_stat = C_AOK;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_icode <= 4'h1;
         r_valE  <= '0;
         r_valM  <= '0;
         r_wdata <= '0;
         r_idx   <= '0;
         r_stat  <= C_AOK;
         r_derr  <= 1'b0;
         r_rd    <= 1'b0;
         r_wr    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_icode <= icode;
                  r_valE  <= valE;
                  r_valM  <= '0;
                  r_wdata <= w_wdata;
                  r_idx   <= IDX_W'(w_word);
                  r_stat  <= w_stat;
                  r_derr  <= w_derr;
                  r_rd    <= w_is_rd;
                  r_wr    <= w_is_wr;
                  if (w_mem && !w_fault) begin
                     r_state <= S_ACCESS;
                     r_cnt   <= 4'(WAIT_CYCLES);
                  end else begin
                     r_state <= S_DONE;
                  end
               end
            end
            S_ACCESS: begin
               if (r_cnt == 4'd0) begin
                  if (r_rd) r_valM <= r_mem[r_idx];
                  r_state <= S_DONE;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_DONE: begin
               if (out_ready) r_state <= (r_stat == C_AOK) ? S_IDLE : S_HALT;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

   // Reset forces r_state to IDLE asynchronously, so a pending write is dropped.
   assign w_commit_wr = (r_state == S_ACCESS) && (r_cnt == 4'd0) && r_wr;

   always_ff @(posedge clk) begin
      if (w_commit_wr) r_mem[r_idx] <= r_wdata;
   end

   assign in_ready   = (r_state == S_IDLE);
   assign out_valid  = (r_state == S_DONE);
   assign out_icode  = r_icode;
   assign out_valE   = r_valE;
   assign valM       = r_valM;
   assign stat       = r_stat;
   assign dmem_error = r_derr;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_pipe.sv
`default_nettype none
// Directed bench: three stage instances with WAIT_CYCLES of 0, 3 and 4.
module tb_mem_stage_pipe;
   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int DEP = 64;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [3];
   logic        in_valid [3];
   logic        out_ready [3];
   logic [3:0]  icode;
   logic [31:0] valA, valE, valP;
   logic        instr_valid, imem_error;
   logic        in_ready [3];
   logic        out_valid [3];
   logic        dmem_error [3];
   logic [3:0]  out_icode [3];
   logic [31:0] out_valE [3];
   logic [31:0] valM [3];
   logic [2:0]  stat [3];

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  ic;
      logic [31:0] a, e, p;
      logic [2:0]  st;
      logic [31:0] m;
      int          lat;
   } vec_t;
   vec_t tbl [12];

   mem_stage_pipe #(.DATA_WID(DW), .ADDR_WID(AW), .DEPTH(DEP), .WAIT_CYCLES(0)) u0 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .icode(icode), .valA(valA), .valE(valE), .valP(valP),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_icode(out_icode[0]),
      .out_valE(out_valE[0]), .valM(valM[0]), .stat(stat[0]), .dmem_error(dmem_error[0]));

   mem_stage_pipe #(.DATA_WID(DW), .ADDR_WID(AW), .DEPTH(DEP), .WAIT_CYCLES(3)) u3 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .icode(icode), .valA(valA), .valE(valE), .valP(valP),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_icode(out_icode[1]),
      .out_valE(out_valE[1]), .valM(valM[1]), .stat(stat[1]), .dmem_error(dmem_error[1]));

   mem_stage_pipe #(.DATA_WID(DW), .ADDR_WID(AW), .DEPTH(DEP), .WAIT_CYCLES(4)) u4 (
      .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .icode(icode), .valA(valA), .valE(valE), .valP(valP),
      .instr_valid(instr_valid), .imem_error(imem_error),
      .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_icode(out_icode[2]),
      .out_valE(out_valE[2]), .valM(valM[2]), .stat(stat[2]), .dmem_error(dmem_error[2]));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_rst(input int k);
      @(negedge clk);
      rst[k] = 1'b1;
      @(negedge clk);
      rst[k] = 1'b0;
   endtask

   // One instruction: accept, measure latency, check result, optionally hold, handshake.
   task automatic do_op(input int k, input logic [3:0] ic, input logic [31:0] a,
                        input logic [31:0] e, input logic [31:0] p, input logic iv,
                        input logic im, input logic [2:0] es, input logic [31:0] em,
                        input logic ed, input int elat, input int hold, input bit pre);
      int lat;
      @(negedge clk);
      chk("in_ready_pre", in_ready[k], 1);
      icode = ic; valA = a; valE = e; valP = p;
      instr_valid = iv; imem_error = im;
      in_valid[k] = 1'b1;
      out_ready[k] = pre;
      @(posedge clk);
      #1;
      in_valid[k] = 1'b0;
      icode = 4'h5; valA = 32'h5A5A5A5A; valE = 32'hA5A5A5A4; valP = 32'h0F0F0F0F;
      instr_valid = 1'b1; imem_error = 1'b0;
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid[k]) break;
      end
      chk("latency", lat, elat);
      if (!out_valid[k]) begin
         out_ready[k] = 1'b0;
         return;
      end
      chk("stat", stat[k], es);
      chk("valM", valM[k], em);
      chk("dmem_error", dmem_error[k], ed);
      chk("out_icode", out_icode[k], ic);
      chk("out_valE", out_valE[k], e);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_valid", out_valid[k], 1);
         chk("hold_valM", valM[k], em);
         chk("hold_stat", stat[k], es);
      end
      out_ready[k] = 1'b1;
      @(posedge clk);
      #1;
      out_ready[k] = 1'b0;
      @(negedge clk);
      chk("post_in_ready", in_ready[k], (es == 3'd1));
      chk("post_out_valid", out_valid[k], 0);
   endtask

   initial begin
      bit ok;
      for (int k = 0; k < 3; k++) begin
         rst[k] = 1'b1; in_valid[k] = 1'b0; out_ready[k] = 1'b0;
      end
      icode = 4'h1; valA = '0; valE = '0; valP = '0;
      instr_valid = 1'b1; imem_error = 1'b0;

      tbl[0]  = '{4'h4, 32'hDEADBEEF, 32'h10,  32'h0,  3'd1, 32'h0,        2};
      tbl[1]  = '{4'h5, 32'h0,        32'h10,  32'h0,  3'd1, 32'hDEADBEEF, 2};
      tbl[2]  = '{4'h6, 32'h3,        32'h5,   32'h0,  3'd1, 32'h0,        1};
      tbl[3]  = '{4'hA, 32'hCAFE0001, 32'h20,  32'h0,  3'd1, 32'h0,        2};
      tbl[4]  = '{4'hB, 32'h20,       32'h1C,  32'h0,  3'd1, 32'hCAFE0001, 2};
      tbl[5]  = '{4'h8, 32'h0,        32'h30,  32'h77, 3'd1, 32'h0,        2};
      tbl[6]  = '{4'h9, 32'h30,       32'h34,  32'h0,  3'd1, 32'h77,       2};
      tbl[7]  = '{4'h3, 32'h0,        32'h99,  32'h0,  3'd1, 32'h0,        1};
      tbl[8]  = '{4'h4, 32'h5555AAAA, 32'hFC,  32'h0,  3'd1, 32'h0,        2};
      tbl[9]  = '{4'h5, 32'h0,        32'hFC,  32'h0,  3'd1, 32'h5555AAAA, 2};
      tbl[10] = '{4'h4, 32'h00001111, 32'h0,   32'h0,  3'd1, 32'h0,        2};
      tbl[11] = '{4'h5, 32'hFC,       32'h0,   32'h0,  3'd1, 32'h00001111, 2};

      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++) rst[k] = 1'b0;
      @(negedge clk);

      chk("rst_in_ready", in_ready[0], 1);
      chk("rst_out_valid", out_valid[0], 0);
      chk("rst_valM", valM[0], 0);
      chk("rst_out_valE", out_valE[0], 0);
      chk("rst_out_icode", out_icode[0], 1);
      chk("rst_stat", stat[0], 1);
      chk("rst_dmem_error", dmem_error[0], 0);

      for (int i = 0; i < 12; i++)
         do_op(0, tbl[i].ic, tbl[i].a, tbl[i].e, tbl[i].p, 1'b1, 1'b0,
               tbl[i].st, tbl[i].m, 1'b0, tbl[i].lat, 0, 1'b0);

      // Out-of-range write must not alias onto word 0
      do_op(0, 4'h4, 32'h9999, 32'h100, 0, 1, 0, 3'd3, 0, 1, 1, 0, 0);
      chk("halt_in_ready", in_ready[0], 0);
      chk("halt_stat", stat[0], 3);
      chk("halt_dmem", dmem_error[0], 1);
      chk("halt_icode", out_icode[0], 4);
      do_rst(0);
      do_op(0, 4'h5, 0, 32'h100, 0, 1, 0, 3'd3, 0, 1, 1, 0, 0);
      do_rst(0);
      do_op(0, 4'h5, 0, 32'h0, 0, 1, 0, 3'd1, 32'h00001111, 0, 2, 0, 0);

      // Misaligned read and write
      do_op(0, 4'h5, 0, 32'h12, 0, 1, 0, 3'd3, 0, 1, 1, 0, 0);
      chk("mis_halt_in_ready", in_ready[0], 0);
      do_rst(0);
      do_op(0, 4'h4, 32'h0, 32'h11, 0, 1, 0, 3'd3, 0, 1, 1, 0, 0);
      do_rst(0);
      do_op(0, 4'h5, 0, 32'h10, 0, 1, 0, 3'd1, 32'hDEADBEEF, 0, 2, 0, 0);

      // HLT then ignored input for 20 cycles
      do_op(0, 4'h0, 0, 32'h8, 0, 1, 0, 3'd2, 0, 0, 1, 0, 0);
      @(negedge clk);
      icode = 4'h5; valE = 32'h10; in_valid[0] = 1'b1;
      ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b0 || stat[0] !== 3'd2) ok = 1'b0;
      end
      chk("halt_ignores_input", ok, 1);
      in_valid[0] = 1'b0;
      do_rst(0);
      @(negedge clk);
      chk("rst_exit_in_ready", in_ready[0], 1);
      chk("rst_exit_stat", stat[0], 1);

      // ADR outranks INS; faulted PUSHL writes nothing
      do_op(0, 4'hA, 32'hBAD, 32'h20, 0, 0, 1, 3'd3, 0, 0, 1, 0, 0);
      do_rst(0);
      do_op(0, 4'hB, 32'h20, 32'h0, 0, 1, 0, 3'd1, 32'hCAFE0001, 0, 2, 0, 0);
      do_op(0, 4'h5, 0, 32'h10, 0, 0, 0, 3'd4, 0, 0, 1, 0, 0);
      do_rst(0);

      // WAIT_CYCLES=3: CALL/RET, RET with out_ready already high
      do_op(1, 4'h8, 0, 32'h40, 32'h123, 1, 0, 3'd1, 0, 0, 5, 0, 0);
      do_op(1, 4'h9, 32'h40, 32'h0, 0, 1, 0, 3'd1, 32'h123, 0, 5, 0, 1);

      // WAIT_CYCLES=4: reset mid-ACCESS drops the write
      do_op(2, 4'h4, 32'h0BADF00D, 32'h20, 0, 1, 0, 3'd1, 0, 0, 6, 0, 0);
      @(negedge clk);
      icode = 4'hA; valE = 32'h20; valA = 32'hFFFF0000; instr_valid = 1'b1; imem_error = 1'b0;
      in_valid[2] = 1'b1;
      @(posedge clk);
      #1;
      in_valid[2] = 1'b0;
      repeat (2) @(negedge clk);
      chk("access_busy", in_ready[2], 0);
      rst[2] = 1'b1;
      #1;
      chk("async_rst_in_ready", in_ready[2], 1);
      @(negedge clk);
      rst[2] = 1'b0;
      do_op(2, 4'h5, 0, 32'h20, 0, 1, 0, 3'd1, 32'h0BADF00D, 0, 6, 6, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
